id_ex_skid_reg: RTL and testbench
=================================

# id_ex_skid_reg

Parametrised ID/EX pipeline register for the 32-bit datapath, sitting between register-file read (Stage 1) and ALU execute (Stage 2). It carries operands and control fields forward like the basic stage register, and adds:
- a valid/ready handshake on both sides, with a 2-entry skid buffer, so a downstream stall never drops an in-flight instruction and in_ready is a registered signal;
- a synchronous Flush that squashes every held instruction;
- an occupancy output for the hazard unit.

## Interface
Parameters:
- N, 32, operand data width (RF_RD1/RF_RD2).
- IMM_W, 16, immediate width.
- OP_W, 3, ALUOp width.
- WS_W, 5, write-select (register index) width.

Ports:
- Clk  input  1  clock; everything updates on posedge Clk.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous squash of all held entries.
- In_Valid  input  1  Stage 1 presents a valid instruction.
- In_Ready  output  1  registered; block can accept this cycle.
- RF_RD1, RF_RD2  input  N  register-file read data.
- S1_IMM  input  IMM_W  immediate.
- S1_DS  input  1  data source (I/R format).
- S1_ALUOp  input  OP_W  ALU operation.
- S1_WS  input  WS_W  write select.
- S1_WE  input  1  register write enable.
- Out_Valid  output  1  S2_* fields hold a valid instruction.
- Out_Ready  input  1  Stage 2 consumes this cycle.
- S2_RD1, S2_RD2, S2_IMM, S2_DS, S2_ALUOp, S2_WS  output  matching widths  fields of the head entry.
- S2_WE  output  1  head entry's WE AND Out_Valid.
- Count  output  2  occupancy, 0..2.

## Operation
- Storage: main entry (drives the S2_* outputs) and skid entry. Each entry holds all seven fields.
- Accept: in_fire = In_Valid & In_Ready.
- Consume: out_fire = Out_Valid & Out_Ready.
- States: EMPTY (Count=0), ONE (Count=1), FULL (Count=2).
- EMPTY: in_fire loads main and moves to ONE. Otherwise stay in EMPTY.
- ONE:
  - in_fire & out_fire: main <= input; stay in ONE.
  - out_fire only: go to EMPTY; main contents are retained but invalid.
  - in_fire only: skid <= input; go to FULL.
  - Neither: hold.
- FULL: In_Ready=0, so in_fire cannot occur. out_fire: main <= skid; go to ONE. Otherwise hold.
- In_Ready is a registered signal: next In_Ready = (next state != FULL).
- Flush (Reset low):
  - next state is EMPTY; In_Ready <= 1.
  - main and skid fields are cleared to 0.
  - Flush overrides a same-cycle in_fire (input dropped) and out_fire (Stage 2 still sees the current head that cycle).
- Reset has priority over Flush and behaves identically to it.
- Invariants: no entry is ever lost or duplicated, and order is strictly FIFO.

## Timing
- Reset values:
  - Out_Valid=0, In_Ready=1, Count=0, S2_WE=0.
  - S2_RD1=S2_RD2=0, S2_IMM=0, S2_DS=0, S2_ALUOp=0, S2_WS=0; skid cleared.
- Latency: input accepted at edge k appears on S2_* with Out_Valid=1 after edge k (one cycle) when the block was EMPTY, or when it was ONE with out_fire.
- Throughput: one instruction per cycle while Out_Ready=1.
- Stalls:
  - The first stalled cycle still accepts one instruction into skid.
  - In_Ready drops the cycle after the skid entry fills.
  - In_Ready rises the cycle after the skid entry drains.
- Out_Valid, S2_*, Count and In_Ready are all registered. S2_WE is the only combinational output: stored WE AND Out_Valid.
- Inputs are sampled only on in_fire. Out_Ready is sampled only when Out_Valid=1.
- Reset or Flush mid-stall (FULL): both entries are discarded, and Out_Valid=0 on the next cycle.

## Test plan
- Reset with junk on every input, held 2 cycles -> every output at its reset value; In_Ready=1, Count=0.
- Streaming: RD1=1..5, WS=1..5, WE=1 on back-to-back cycles, Out_Ready=1 -> S2_RD1=1..5 one cycle later each, Out_Valid continuous, Count=1, In_Ready always 1.
- Stall: send A (RD1=0xA), B (0xB), C (0xC) with Out_Ready=0 -> Count reaches 2 and In_Ready=0. C is not accepted and is held by the source, with In_Valid kept high and inputs stable, until In_Ready returns to 1. Release Out_Ready -> output order A, B, then C; C is accepted the cycle after B moves to main, with no loss or duplication.
- Simultaneous fire in ONE: head=A, input D with Out_Ready=1 -> next cycle S2_RD1=D, Count=1.
- Flush while FULL, with In_Valid=1 asserted the same cycle -> next cycle Out_Valid=0, S2_WE=0, Count=0, In_Ready=1, all fields 0; the flushed-cycle input is absent from output.
- S2_WE gating: instruction with S1_WE=1 consumed, then EMPTY -> S2_WE=0 while S2_WS still shows the stale index.

Source files
------------

// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg
//   ID/EX pipeline register with a valid/ready handshake on both sides and a
//   2-entry skid buffer (main + skid). A downstream stall never drops an
//   in-flight instruction. In_Ready is registered, so the upstream timing
//   path does not see Out_Ready combinationally.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   Flush                 synchronous squash of every held entry
//   In_Valid / In_Ready   Stage 1 handshake (In_Ready registered)
//   RF_RD1, RF_RD2, S1_*  instruction fields from register-file read
//   Out_Valid / Out_Ready Stage 2 handshake
//   S2_*                  fields of the head (main) entry
//   S2_WE                 head WE gated by Out_Valid (only combinational output)
//   Count                 occupancy 0..2 for the hazard unit
module id_ex_skid_reg #(
  parameter int N     = 32,
  parameter int IMM_W = 16,
  parameter int OP_W  = 3,
  parameter int WS_W  = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [N-1:0]     RF_RD1,
  input  logic [N-1:0]     RF_RD2,
  input  logic [IMM_W-1:0] S1_IMM,
  input  logic             S1_DS,
  input  logic [OP_W-1:0]  S1_ALUOp,
  input  logic [WS_W-1:0]  S1_WS,
  input  logic             S1_WE,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [N-1:0]     S2_RD1,
  output logic [N-1:0]     S2_RD2,
  output logic [IMM_W-1:0] S2_IMM,
  output logic             S2_DS,
  output logic [OP_W-1:0]  S2_ALUOp,
  output logic [WS_W-1:0]  S2_WS,
  output logic             S2_WE,
  output logic [1:0]       Count
);

  typedef struct packed {
    logic [N-1:0]     rd1;
    logic [N-1:0]     rd2;
    logic [IMM_W-1:0] imm;
    logic             ds;
    logic [OP_W-1:0]  alu_op;
    logic [WS_W-1:0]  ws;
    logic             we;
  } entry_t;

  // Encoding equals occupancy so Count comes straight from the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;

  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{rd1: RF_RD1, rd2: RF_RD2, imm: S1_IMM, ds: S1_DS,
                      alu_op: S1_ALUOp, ws: S1_WS, we: S1_WE};

  assign in_fire  = In_Valid & in_ready_q;
  assign out_fire = out_valid_q & Out_Ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (out_fire) begin
          // Main keeps its stale contents; Out_Valid marks it invalid.
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = FULL;
        end
      end
      FULL: begin
        // in_ready_q is low here, so only the drain side can move.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over any same-cycle accept; the current head is still
    // visible to Stage 2 during the flush cycle itself.
    if (Flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Count     = state_q;
  assign S2_RD1    = main_q.rd1;
  assign S2_RD2    = main_q.rd2;
  assign S2_IMM    = main_q.imm;
  assign S2_DS     = main_q.ds;
  assign S2_ALUOp  = main_q.alu_op;
  assign S2_WS     = main_q.ws;
  assign S2_WE     = main_q.we & out_valid_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Testbench for id_ex_skid_reg: a table of per-cycle vectors with hand-derived
// expected outputs, plus a scoreboard queue tracking accepted instructions.
module tb_id_ex_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] rf_rd1, rf_rd2, s2_rd1, s2_rd2;
  logic [15:0] s1_imm, s2_imm;
  logic        s1_ds, s2_ds, s1_we, s2_we;
  logic [2:0]  s1_op, s2_op;
  logic [4:0]  s1_ws, s2_ws;
  logic [1:0]  count;

  always #5 clk = ~clk;

  id_ex_skid_reg dut (
    .Clk(clk), .Reset(rst), .Flush(flush),
    .In_Valid(in_valid), .In_Ready(in_ready),
    .RF_RD1(rf_rd1), .RF_RD2(rf_rd2), .S1_IMM(s1_imm), .S1_DS(s1_ds),
    .S1_ALUOp(s1_op), .S1_WS(s1_ws), .S1_WE(s1_we),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .S2_RD1(s2_rd1), .S2_RD2(s2_rd2), .S2_IMM(s2_imm), .S2_DS(s2_ds),
    .S2_ALUOp(s2_op), .S2_WS(s2_ws), .S2_WE(s2_we), .Count(count)
  );

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] imm;
    logic        ds;
    logic [2:0]  op;
    logic [4:0]  ws;
    logic        we;
  } item_t;

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [31:0] rd1;
    logic [4:0]  ws;
    logic        we;
    logic [1:0]  e_cnt;
    logic        e_ir, e_ov;
    logic [31:0] e_rd1;
    logic        e_we;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  item_t sb_q[$];
  item_t stale;
  logic  model_ok = 1'b0;
  logic  m_ready  = 1'b1;
  vec_t  vecs[$];

  function automatic vec_t mk(logic r, logic f, logic iv, logic o,
                              logic [31:0] d, logic [4:0] ws, logic we,
                              logic [1:0] ec, logic eir, logic eov,
                              logic [31:0] erd1, logic ewe);
    vec_t v;
    v.rst = r; v.fl = f; v.iv = iv; v.ordy = o; v.rd1 = d; v.ws = ws; v.we = we;
    v.e_cnt = ec; v.e_ir = eir; v.e_ov = eov; v.e_rd1 = erd1; v.e_we = ewe;
    return v;
  endfunction

  function automatic item_t make_item(logic [31:0] d, logic [4:0] ws, logic we);
    item_t it;
    it.rd1 = d;
    it.rd2 = ~d;
    it.imm = d[15:0] ^ 16'h5a5a;
    it.ds  = d[0];
    it.op  = d[2:0] ^ 3'b101;
    it.ws  = ws;
    it.we  = we;
    return it;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Mid-cycle check of the DUT against the scoreboard model.
  task automatic sb_check();
    item_t e;
    logic  e_valid;
    e_valid = (sb_q.size() != 0);
    e = e_valid ? sb_q[0] : stale;
    chk("sb_count",     96'(count),     96'(sb_q.size()));
    chk("sb_in_ready",  96'(in_ready),  96'(m_ready));
    chk("sb_out_valid", 96'(out_valid), 96'(e_valid));
    chk("sb_fields", 96'({s2_rd1, s2_rd2, s2_imm, s2_ds, s2_op, s2_ws}),
                     96'({e.rd1, e.rd2, e.imm, e.ds, e.op, e.ws}));
    chk("sb_we",        96'(s2_we),     96'(e_valid & e.we));
  endtask

  task automatic step(input vec_t v);
    item_t it;
    item_t popped;
    logic  in_f, out_f;
    it        = make_item(v.rd1, v.ws, v.we);
    rst       = v.rst;
    flush     = v.fl;
    in_valid  = v.iv;
    out_ready = v.ordy;
    rf_rd1 = it.rd1; rf_rd2 = it.rd2; s1_imm = it.imm; s1_ds = it.ds;
    s1_op  = it.op;  s1_ws  = it.ws;  s1_we  = it.we;
    @(negedge clk);
    if (model_ok) sb_check();
    in_f  = v.iv && m_ready;
    out_f = (sb_q.size() != 0) && v.ordy;
    @(posedge clk);
    if (v.rst || v.fl) begin
      sb_q.delete();
      stale    = '0;
      model_ok = 1'b1;
    end else begin
      if (out_f) begin
        popped = sb_q.pop_front();
        if (!in_f && sb_q.size() == 0) stale = popped;
      end
      if (in_f) sb_q.push_back(it);
    end
    m_ready = (sb_q.size() != 2);
    #1;
  endtask

  initial begin
    stale = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rf_rd1 = '0; rf_rd2 = '0; s1_imm = '0; s1_ds = 1'b0;
    s1_op = '0; s1_ws = '0; s1_we = 1'b0;

    //                 rst fl iv or data          ws  we   cnt ir ov e_rd1         e_we
    // Reset with junk on every input, two cycles
    vecs.push_back(mk(1, 1, 1, 1, 32'hDEADBEEF, 31, 1,  0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h12345678,  9, 1,  0, 1, 0, 32'h0, 0));
    // Streaming 1..5, then drain
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(0, 0, 1, 1, 32'(i), 5'(i), 1,  1, 1, 1, 32'(i), 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,   0, 0,  0, 1, 0, 32'h5, 0));
    // Stall: A, B fill; C held by source until In_Ready returns
    vecs.push_back(mk(0, 0, 1, 0, 32'hA,  10, 1,  1, 1, 1, 32'hA, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'hB,  11, 0,  2, 0, 1, 32'hA, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC,  12, 1,  2, 0, 1, 32'hA, 1));
    vecs.push_back(mk(0, 0, 1, 1, 32'hC,  12, 1,  1, 1, 1, 32'hB, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hC,  12, 1,  1, 1, 1, 32'hC, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,   0, 0,  0, 1, 0, 32'hC, 0));
    // Simultaneous fire in ONE, then fill to FULL and flush with In_Valid high
    vecs.push_back(mk(0, 0, 1, 0, 32'hA,   3, 0,  1, 1, 1, 32'hA, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'hD,   4, 1,  1, 1, 1, 32'hD, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'hE,   5, 1,  2, 0, 1, 32'hD, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'hF,   6, 1,  0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,   0, 0,  0, 1, 0, 32'h0, 0));
    // S2_WE gating after drain (stale WS=7 checked by scoreboard)
    vecs.push_back(mk(0, 0, 1, 0, 32'h77,  7, 1,  1, 1, 1, 32'h77, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,   0, 0,  0, 1, 0, 32'h77, 0));
    // Flush in ONE overriding both in_fire and out_fire
    vecs.push_back(mk(0, 0, 1, 0, 32'h88,  8, 1,  1, 1, 1, 32'h88, 1));
    vecs.push_back(mk(0, 1, 1, 1, 32'h99,  9, 1,  0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,   0, 0,  0, 1, 0, 32'h0, 0));
    // Reset while FULL
    vecs.push_back(mk(0, 0, 1, 0, 32'h91, 17, 1,  1, 1, 1, 32'h91, 1));
    vecs.push_back(mk(0, 0, 1, 0, 32'h92, 18, 1,  2, 0, 1, 32'h91, 1));
    vecs.push_back(mk(1, 0, 1, 1, 32'h93, 19, 1,  0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,   0, 0,  0, 1, 0, 32'h0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      chk($sformatf("v%0d_count", i),     96'(count),     96'(vecs[i].e_cnt));
      chk($sformatf("v%0d_in_ready", i),  96'(in_ready),  96'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), 96'(out_valid), 96'(vecs[i].e_ov));
      chk($sformatf("v%0d_s2_rd1", i),    96'(s2_rd1),    96'(vecs[i].e_rd1));
      chk($sformatf("v%0d_s2_we", i),     96'(s2_we),     96'(vecs[i].e_we));
    end

    // Randomised traffic against the scoreboard only
    for (int i = 0; i < 200; i++)
      step(mk(0, ($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
              $urandom, 5'($urandom), 1'($urandom), 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    sb_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
